// File: rtl/switch_debounce_sync_pkg.sv
// -----------------------------------------------------------------------------
// switch_debounce_sync_pkg
// Shared constants and helpers for switch/button conditioning blocks.
//   DEF_WIDTH          : default number of switch lines
//   DEF_TICK_DIV       : default clk cycles per debounce tick (1 ms at 50 MHz)
//   DEF_DEBOUNCE_TICKS : default ticks of sustained mismatch before adopting
//   cnt_width()        : bits needed to hold values 0..max_val (at least 1)
// -----------------------------------------------------------------------------
package switch_debounce_sync_pkg;

  localparam int unsigned DEF_WIDTH          = 8;
  localparam int unsigned DEF_TICK_DIV       = 50000;
  localparam int unsigned DEF_DEBOUNCE_TICKS = 10;

  // Width of a counter that must represent every value in 0..max_val.
  // Never returns 0 so a degenerate range still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_sync_if.sv
// -----------------------------------------------------------------------------
// switch_debounce_sync_if
// Bundle between the raw switch pins, the conditioning block and its
// consumers (switch PIO in_port, future edge-capture/interrupt logic).
//   sw_raw     : asynchronous raw switch levels
//   sw_clean   : debounced, synchronous switch levels
//   sw_rise    : one-cycle per-bit pulse on a 0->1 change of sw_clean
//   sw_fall    : one-cycle per-bit pulse on a 1->0 change of sw_clean
//   sw_changed : one-cycle pulse when any bit of sw_clean changes
//   tick       : shared debounce timebase tick
// Modports:
//   master : the conditioning block (consumes sw_raw, drives the rest)
//   slave  : the surrounding system (drives sw_raw, observes the rest)
// These are continuous level/pulse signals; there is no valid/ready
// handshake, a pulse is simply high for one clk cycle and must be sampled then.
// -----------------------------------------------------------------------------
interface switch_debounce_sync_if
  import switch_debounce_sync_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;
  logic             tick;

  modport master (
    input  sw_raw,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output sw_changed,
    output tick
  );

  modport slave (
    output sw_raw,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed,
    input  tick
  );

endinterface

// File: rtl/switch_debounce_sync_debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// Conditions a single switch line: 2-FF synchroniser, tick-qualified
// mismatch counter, clean level flop and registered edge pulses.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   i_raw        : asynchronous raw switch level
//   i_tick       : registered timebase tick shared by all bits
//   o_clean      : debounced level
//   o_rise       : one-cycle pulse, coincident with o_clean going 0->1
//   o_fall       : one-cycle pulse, coincident with o_clean going 1->0
//   o_settle     : combinational "o_clean changes on this edge"; lets the
//                  parent register an aggregate strobe in the same edge
// -----------------------------------------------------------------------------
module debounce_bit
  import switch_debounce_sync_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter logic        RESET_BIT      = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall,
  output logic o_settle
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_clean;
  logic          r_rise;
  logic          r_fall;

  logic          w_mismatch;
  logic          w_settle;

  assign w_mismatch = (r_sync2 != r_clean);
  // The final qualifying tick of an unbroken mismatch run.
  assign w_settle   = w_mismatch && i_tick && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= RESET_BIT;
      r_sync2 <= RESET_BIT;
      r_cnt   <= '0;
      r_clean <= RESET_BIT;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (!w_mismatch) begin
        // Any return to the clean level discards progress.
        r_cnt <= '0;
      end else if (i_tick) begin
        if (w_settle) begin
          r_clean <= r_sync2;
          r_cnt   <= '0;
          r_rise  <= r_sync2;
          r_fall  <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_clean  = r_clean;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_settle = w_settle;

endmodule

// File: rtl/switch_debounce_sync.sv
// -----------------------------------------------------------------------------
// switch_debounce_sync
// Conditioning stage between the board slide switches and the switch PIO.
// Each raw line is synchronised into clk and debounced against a shared
// prescaled tick; the clean vector feeds the PIO in_port directly, with
// per-bit rise/fall pulses and an aggregate change strobe alongside.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous assert, active-low reset
//   bus     : switch_debounce_sync_if.master (sw_raw in; sw_clean, sw_rise,
//             sw_fall, sw_changed, tick out)
// Parameters:
//   WIDTH          : number of switch lines
//   TICK_DIV       : clk cycles per tick (>= 1; 1 ticks every cycle)
//   DEBOUNCE_TICKS : consecutive mismatching ticks before adopting (>= 1)
//   RESET_VALUE    : reset value of synchronisers and sw_clean
// -----------------------------------------------------------------------------
module switch_debounce_sync
  import switch_debounce_sync_pkg::*;
#(
  parameter int unsigned      WIDTH          = DEF_WIDTH,
  parameter int unsigned      TICK_DIV       = DEF_TICK_DIV,
  parameter int unsigned      DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input logic                   clk,
  input logic                   reset_n,
  switch_debounce_sync_if.master bus
);

  localparam int unsigned PW = cnt_width(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    r_presc;
  logic             r_tick;
  logic             r_changed;

  logic [WIDTH-1:0] w_clean;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_settle;

  // Shared timebase: counts 0..TICK_DIV-1; the registered tick is high for
  // the one cycle following the wrap, so every bit sees the same phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
      r_tick  <= 1'b0;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .RESET_BIT      (RESET_VALUE[g])
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_raw    (bus.sw_raw[g]),
      .i_tick   (r_tick),
      .o_clean  (w_clean[g]),
      .o_rise   (w_rise[g]),
      .o_fall   (w_fall[g]),
      .o_settle (w_settle[g])
    );
  end

  // Registered from the per-bit settle terms so it lands in the same cycle
  // as the edge pulses; several bits settling together give one pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_settle;
    end
  end

  assign bus.sw_clean   = w_clean;
  assign bus.sw_rise    = w_rise;
  assign bus.sw_fall    = w_fall;
  assign bus.sw_changed = r_changed;
  assign bus.tick       = r_tick;

endmodule

// File: tb/tb_switch_debounce_sync.sv
module tb_switch_debounce_sync;

  localparam int W  = 8;
  localparam int TD = 4;
  localparam int DT = 3;

  logic clk;
  logic reset_n;

  switch_debounce_sync_if #(.WIDTH(W)) bus_if ();

  switch_debounce_sync #(
    .WIDTH          (W),
    .TICK_DIV       (TD),
    .DEBOUNCE_TICKS (DT),
    .RESET_VALUE    (8'h00)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Synchroniser is a 2-deep delay line of raw samples; the tick is a pure
  // function of edges since reset release; each bit counts ticks seen during
  // an unbroken disagreement and adopts the new level on the DT-th one.
  logic [W-1:0] m_pipe[$];
  logic [W-1:0] m_clean, m_rise, m_fall;
  logic         m_chg, m_tick;
  int           m_k;
  int           m_ticks[W];

  task automatic model_reset();
    m_pipe.delete();
    m_pipe.push_back(8'h00);
    m_pipe.push_back(8'h00);
    m_clean = 8'h00;
    m_rise  = 8'h00;
    m_fall  = 8'h00;
    m_chg   = 1'b0;
    m_tick  = 1'b0;
    m_k     = 0;
    for (int i = 0; i < W; i++) m_ticks[i] = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] sync_pre;
    logic         tick_pre;
    if (!reset_n) begin
      model_reset();
      return;
    end
    sync_pre = m_pipe[0];
    tick_pre = m_tick;
    void'(m_pipe.pop_front());
    m_pipe.push_back(bus_if.sw_raw);
    m_k++;
    m_tick = ((m_k % TD) == 0);
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) begin
      if (sync_pre[i] == m_clean[i]) begin
        m_ticks[i] = 0;
      end else if (tick_pre) begin
        m_ticks[i]++;
        if (m_ticks[i] == DT) begin
          m_ticks[i]  = 0;
          m_clean[i]  = sync_pre[i];
          m_rise[i]   = sync_pre[i];
          m_fall[i]   = ~sync_pre[i];
        end
      end
    end
    m_chg = |(m_rise | m_fall);
  endtask

  task automatic compare_all();
    check("clean",   32'(bus_if.sw_clean),   32'(m_clean));
    check("rise",    32'(bus_if.sw_rise),    32'(m_rise));
    check("fall",    32'(bus_if.sw_fall),    32'(m_fall));
    check("changed", 32'(bus_if.sw_changed), 32'(m_chg));
    check("tick",    32'(bus_if.tick),       32'(m_tick));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change only at the falling edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_hold(input int n, output logic [W-1:0] ra, output logic [W-1:0] fa,
                          output int cc, output int first);
    ra = '0; fa = '0; cc = 0; first = 0;
    for (int c = 1; c <= n; c++) begin
      step();
      ra |= bus_if.sw_rise;
      fa |= bus_if.sw_fall;
      if (bus_if.sw_changed) begin
        cc++;
        if (first == 0) first = c;
      end
    end
  endtask

  typedef struct {
    logic [W-1:0] raw;
    int           hold;
    logic [W-1:0] exp_clean;
    logic [W-1:0] exp_rise;
    logic [W-1:0] exp_fall;
    int           exp_pulses;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [W-1:0] ra, fa, ra2, fa2;
    int cc, cc2, first, first2, bchg;

    vecs[0] = '{8'h00, 20, 8'h00, 8'h00, 8'hFF, 1};
    vecs[1] = '{8'h01, 20, 8'h01, 8'h01, 8'h00, 1};
    vecs[2] = '{8'h02, 20, 8'h02, 8'h02, 8'h01, 1};
    vecs[3] = '{8'h81, 20, 8'h81, 8'h81, 8'h02, 1};
    vecs[4] = '{8'h81, 20, 8'h81, 8'h00, 8'h00, 0};

    // ---- reset with all switches already on ----
    reset_n       = 1'b0;
    bus_if.sw_raw = 8'hFF;
    model_reset();
    #1;
    check("rst_clean_async", 32'(bus_if.sw_clean), 32'h00);
    for (int i = 0; i < 3; i++) step();
    check("rst_clean",   32'(bus_if.sw_clean),   32'h00);
    check("rst_pulses",  32'(bus_if.sw_rise | bus_if.sw_fall), 32'h00);
    check("rst_changed", 32'(bus_if.sw_changed), 32'h0);
    check("rst_tick",    32'(bus_if.tick),       32'h0);
    reset_n = 1'b1;
    run_hold(14, ra, fa, cc, first);
    check("rel_clean",  32'(bus_if.sw_clean), 32'hFF);
    check("rel_rise",   32'(ra), 32'hFF);
    check("rel_fall",   32'(fa), 32'h00);
    check("rel_pulses", 32'(cc), 32'd1);

    // ---- table of level steps ----
    for (int v = 0; v < 5; v++) begin
      bus_if.sw_raw = vecs[v].raw;
      run_hold(vecs[v].hold, ra, fa, cc, first);
      check($sformatf("vec%0d_clean", v),  32'(bus_if.sw_clean), 32'(vecs[v].exp_clean));
      check($sformatf("vec%0d_rise", v),   32'(ra), 32'(vecs[v].exp_rise));
      check($sformatf("vec%0d_fall", v),   32'(fa), 32'(vecs[v].exp_fall));
      check($sformatf("vec%0d_pulses", v), 32'(cc), 32'(vecs[v].exp_pulses));
      if (vecs[v].exp_pulses > 0)
        check($sformatf("vec%0d_latency_ok", v), 32'(first >= 11 && first <= 14), 32'd1);
    end

    // ---- short glitch on bit 3 ----
    bus_if.sw_raw = 8'h89;
    run_hold(8, ra, fa, cc, first);
    bus_if.sw_raw = 8'h81;
    run_hold(20, ra2, fa2, cc2, first2);
    check("glitch_clean",  32'(bus_if.sw_clean), 32'h81);
    check("glitch_pulses", 32'(ra | fa | ra2 | fa2), 32'h00);
    check("glitch_chg",    32'(cc + cc2), 32'd0);

    // ---- bounce on bit 5 then settle high ----
    bchg = 0;
    for (int c = 0; c < 40; c++) begin
      bus_if.sw_raw = 8'h81 | ((((c / 3) % 2) == 0) ? 8'h20 : 8'h00);
      step();
      if (bus_if.sw_changed) bchg++;
    end
    check("bounce_no_chg", 32'(bchg), 32'd0);
    bus_if.sw_raw = 8'hA1;
    run_hold(20, ra, fa, cc, first);
    check("bounce_rise",    32'(ra), 32'h20);
    check("bounce_fall",    32'(fa), 32'h00);
    check("bounce_pulses",  32'(cc), 32'd1);
    check("bounce_latency_ok", 32'(first >= 11 && first <= 14), 32'd1);

    // ---- reset in the middle of a debounce ----
    bus_if.sw_raw = 8'hA3;
    for (int i = 0; i < 6; i++) step();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst_clean", 32'(bus_if.sw_clean), 32'h00);
    for (int i = 0; i < 3; i++) step();
    reset_n = 1'b1;
    run_hold(20, ra, fa, cc, first);
    check("midrst_clean_after", 32'(bus_if.sw_clean), 32'hA3);
    check("midrst_rise",   32'(ra), 32'hA3);
    check("midrst_pulses", 32'(cc), 32'd1);
    check("midrst_latency_ok", 32'(first >= 11 && first <= 14), 32'd1);

    // ---- randomized levels against the model ----
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 1) == 0)
        bus_if.sw_raw = 8'($urandom_range(0, 255));
      else
        bus_if.sw_raw = bus_if.sw_raw ^ (8'h01 << $urandom_range(0, 7));
      for (int c = 0; c < int'($urandom_range(1, 20)); c++) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
